// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake bundle: operands, start/annul request,
// and the registered {remainder, quotient} result with its ready flag.
interface div_unit_if;
   logic        signed_div_input;
   logic [31:0] opdata1_input;
   logic [31:0] opdata2_input;
   logic        start_input;
   logic        annul_input;
   logic [63:0] result_output;
   logic        ready_output;

   // EX side: issues requests, consumes the result.
   modport master (
      output signed_div_input,
      output opdata1_input,
      output opdata2_input,
      output start_input,
      output annul_input,
      input  result_output,
      input  ready_output
   );

   // Divider side.
   modport slave (
      input  signed_div_input,
      input  opdata1_input,
      input  opdata2_input,
      input  start_input,
      input  annul_input,
      output result_output,
      output ready_output
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU. One quotient bit per
// cycle over 32 cycles; operands are reduced to magnitudes on start and the
// signs are reapplied on the final iteration. Result is {remainder, quotient}.
module div_unit (
   input  logic       clock,
   input  logic       reset,
   div_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DIV_BY_ZERO = 2'd1,
      DIV_ON      = 2'd2,
      DIV_END     = 2'd3
   } state_t;

   state_t      state, state_next;
   logic [4:0]  cnt, cnt_next;
   logic [64:0] work, work_next;       // {partial_rem[32:0], dividend_shift[31:0]}
   logic [31:0] divisor, divisor_next; // divisor magnitude
   logic        neg_quot, neg_quot_next;
   logic        neg_rem, neg_rem_next;
   logic [63:0] result, result_next;
   logic        ready, ready_next;

   // Operand magnitudes and sign flags taken at the start sample.
   logic [31:0] abs_a, abs_b;
   logic        start_neg_quot, start_neg_rem;

   // One restoring iteration on the current work register.
   logic [64:0] shifted;
   logic [32:0] trial;
   logic [64:0] iter_work;
   logic [31:0] quot_fixed, rem_fixed;

   // Magnitude/sign extraction of the incoming operands.
   always_comb begin
      abs_a = (bus.signed_div_input && bus.opdata1_input[31]) ?
              (~bus.opdata1_input + 32'd1) : bus.opdata1_input;
      abs_b = (bus.signed_div_input && bus.opdata2_input[31]) ?
              (~bus.opdata2_input + 32'd1) : bus.opdata2_input;
      start_neg_quot = bus.signed_div_input &
                       (bus.opdata1_input[31] ^ bus.opdata2_input[31]);
      start_neg_rem  = bus.signed_div_input & bus.opdata1_input[31];
   end

   // Shift-subtract step plus sign post-correction of the step's outcome.
   always_comb begin
      shifted = work << 1;
      trial   = shifted[64:32] - {1'b0, divisor};
      // A set MSB means the subtraction went negative: keep the shifted
      // value (restore) and shift in a 0; otherwise commit and shift in 1.
      if (trial[32]) begin
         iter_work = shifted;
      end else begin
         iter_work = {trial, shifted[31:1], 1'b1};
      end
      quot_fixed = neg_quot ? (~iter_work[31:0] + 32'd1)  : iter_work[31:0];
      rem_fixed  = neg_rem  ? (~iter_work[63:32] + 32'd1) : iter_work[63:32];
   end

   // Next-state and datapath-register update logic.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      work_next     = work;
      divisor_next  = divisor;
      neg_quot_next = neg_quot;
      neg_rem_next  = neg_rem;
      result_next   = result;
      ready_next    = ready;

      case (state)
         IDLE: begin
            if (bus.start_input && !bus.annul_input) begin
               if (bus.opdata2_input == '0) begin
                  state_next = DIV_BY_ZERO;
               end else begin
                  state_next    = DIV_ON;
                  work_next     = {33'd0, abs_a};
                  divisor_next  = abs_b;
                  neg_quot_next = start_neg_quot;
                  neg_rem_next  = start_neg_rem;
                  cnt_next      = '0;
               end
            end
         end

         DIV_BY_ZERO: begin
            state_next  = DIV_END;
            result_next = '0;
            ready_next  = 1'b1;
         end

         DIV_ON: begin
            if (bus.annul_input) begin
               state_next = IDLE;
               work_next  = '0;
               cnt_next   = '0;
            end else begin
               work_next = iter_work;
               cnt_next  = cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state_next  = DIV_END;
                  result_next = {rem_fixed, quot_fixed};
                  ready_next  = 1'b1;
               end
            end
         end

         DIV_END: begin
            if (!bus.start_input) begin
               state_next  = IDLE;
               result_next = '0;
               ready_next  = 1'b0;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         work     <= '0;
         divisor  <= '0;
         neg_quot <= 1'b0;
         neg_rem  <= 1'b0;
         result   <= '0;
         ready    <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         work     <= work_next;
         divisor  <= divisor_next;
         neg_quot <= neg_quot_next;
         neg_rem  <= neg_rem_next;
         result   <= result_next;
         ready    <= ready_next;
      end
   end

   assign bus.result_output = result;
   assign bus.ready_output  = ready;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. EX raises a start request with operands and holds it while the pipeline is stalled. The divider runs a restoring shift-subtract loop, one quotient bit per cycle, and returns `{remainder, quotient}` with a ready flag. EX writes the result to HI (remainder) and LO (quotient). EX can annul an in-flight division, for example on a pipeline flush.

## Interface
- No parameters; widths fixed (32-bit operands, 64-bit result).
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `signed_div_input` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- `opdata1_input` in 32: dividend; sampled with start.
- `opdata2_input` in 32: divisor; sampled with start.
- `start_input` in 1: division request; level, held by EX until it has consumed ready.
- `annul_input` in 1: abort current division.
- `result_output` out 64: `{remainder[31:0], quotient[31:0]}`; registered.
- `ready_output` out 1: result valid; registered.

## Operation
- States: IDLE, DIV_BY_ZERO, DIV_ON, DIV_END.
- IDLE:
  - start=1 and annul=0, divisor=0 → DIV_BY_ZERO.
  - start=1 and annul=0, divisor≠0 → DIV_ON.
  - On entry to DIV_ON, latch |dividend| and |divisor| (absolute value only when signed and bit31=1), the sign flags, and cnt=0.
  - Otherwise stay in IDLE.
- DIV_BY_ZERO: unconditionally → DIV_END with quotient=0 and remainder=0.
- DIV_ON:
  - annul=1 → IDLE; work registers discarded, no ready.
  - Otherwise perform one iteration:
    - Work register is 65 bits: `{partial_rem[32:0], dividend_shift[31:0]}`.
    - Shift left 1.
    - Trial = `upper 33 bits − {1'b0, divisor}`.
    - Trial non-negative: upper := trial, LSB := 1. Else LSB := 0.
    - cnt++.
  - After iteration 32 (cnt=31 on entry): → DIV_END.
  - Post-correct on that transition:
    - quotient negated (two's complement) if signed and sign(dividend)≠sign(divisor).
    - remainder negated if signed and dividend negative.
- DIV_END:
  - ready_output=1; result_output holds the final value.
  - start=0 → IDLE, ready_output:=0, result_output:=0.
  - start still 1 → stay in DIV_END, outputs held.
  - annul has no effect in DIV_END.
- Arithmetic: all modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (no trap).
- annul and start both high in IDLE: annul wins, stay in IDLE.

## Timing
- Reset (sync): state=IDLE, cnt=0, result_output=0, ready_output=0. This overrides any state, including mid-division.
- Normal latency: edge E0 samples start in IDLE. Edges E1–E32 perform iterations. ready_output is high from just after E32 through the cycle in which start is sampled low.
- Divide-by-zero latency: E0 samples start, E1 enters DIV_END, ready high after E1.
- ready_output falls on the first edge after start is sampled low in DIV_END. The earliest new start is sampled on the following edge, from IDLE.
- Operand inputs are ignored outside the IDLE sampling edge. Changing them mid-division has no effect.
- result_output changes only on entry to DIV_END, or is cleared on DIV_END→IDLE or reset.

## Test plan
- Unsigned 100 / 7:
  - start held → ready high exactly 32 edges after the sampling edge.
  - result=0x00000002_0000000E.
  - Drop start → ready=0 and result=0 next edge.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → result=0xFFFFFFFF_FFFFFFFD. Same operands unsigned → quotient 0x7FFFFFFC, remainder 0x1.
- Divide by zero: 5 / 0 → ready after 2 edges, result=0. Signed 0x80000000 / 0xFFFFFFFF → result=0x00000000_80000000.
- Annul:
  - annul pulsed at iteration 10 → IDLE, ready never asserts.
  - Immediate new start 9 / 3 → result 0x00000000_00000003 with full latency.
  - annul+start together in IDLE → stays IDLE.
- Hold behaviour:
  - start held 5 extra cycles in DIV_END → ready and result stable.
  - Operand inputs toggled during DIV_ON → result unaffected.
- Reset mid-division at iteration 20 → next edge all outputs 0, state IDLE. Subsequent 0xFFFFFFFF / 1 unsigned → result 0x00000000_FFFFFFFF.
